regfile_wb_arbiter: RTL

//  Writeback scheduler for the 16x16 two-write-port register file. Collects write requests from

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/wb_slot_alloc.sv | 87 ++++++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and requester encoding for the register-file writeback scheduler.
package regfile_pkg;

  localparam int DW       = 16;
  localparam int AW       = 4;
  localparam int NUM_REGS = 2 ** AW;

  localparam logic [1:0] RW_NONE = 2'd0;
  localparam logic [1:0] RW_ONE  = 2'd1;
  localparam logic [1:0] RW_TWO  = 2'd2;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_MD  = 2'd2
  } req_id_e;

  // Requester reached after 'step' hops along ALU -> MEM -> MD -> ALU.
  function automatic req_id_e req_at(req_id_e base, logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return req_id_e'(sum[1:0]);
  endfunction

  function automatic req_id_e req_after(req_id_e id);
    return req_at(id, 2'd1);
  endfunction

endpackage

// File: rtl/wb_slot_alloc.sv
// Combinational slot allocator: walks the three requesters from the round-robin pointer and
// packs up to two non-colliding register writes into the two ports.
module wb_slot_alloc
  import regfile_pkg::*;
(
  input  logic [1:0]    ptr,
  input  logic [2:0]    valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] md_reg1,
  input  logic [AW-1:0] md_reg2,
  input  logic [DW-1:0] md_data1,
  input  logic [DW-1:0] md_data2,
  output logic [2:0]    grant,
  output logic [1:0]    first,
  output logic [1:0]    rw,
  output logic [AW-1:0] wreg1,
  output logic [AW-1:0] wreg2,
  output logic [DW-1:0] wdata1,
  output logic [DW-1:0] wdata2
);

  always_comb begin
    req_id_e       id;
    logic [1:0]    slots;
    logic [AW-1:0] sreg;
    logic [DW-1:0] sdata;
    // NOTE: every output and temporary gets a default before the walk, so no path leaves
    // a value unassigned and no latch is inferred.
    grant  = 3'b000;
    first  = ptr;
    rw     = RW_NONE;
    wreg1  = '0;
    wreg2  = '0;
    wdata1 = '0;
    wdata2 = '0;
    slots  = 2'd2;
    id     = REQ_ALU;
    sreg   = '0;
    sdata  = '0;
    for (int i = 0; i < 3; i++) begin
      id = req_at(req_id_e'(ptr), 2'(i));
      case (id)
        REQ_ALU, REQ_MEM: begin
          sreg  = (id == REQ_ALU) ? alu_reg  : mem_reg;
          sdata = (id == REQ_ALU) ? alu_data : mem_data;
          // With one slot left, port1 already holds a write; its register must not repeat.
          if (valid[id] && slots != 2'd0 && !(slots == 2'd1 && sreg == wreg1)) begin
            if (slots == 2'd2) begin
              wreg1  = sreg;
              wdata1 = sdata;
              rw     = RW_ONE;
            end else begin
              wreg2  = sreg;
              wdata2 = sdata;
              rw     = RW_TWO;
            end
            if (grant == 3'b000) first = id;
            grant[id] = 1'b1;
            slots     = slots - 2'd1;
          end
        end
        REQ_MD: begin
          if (valid[REQ_MD] && slots == 2'd2) begin
            wreg1 = md_reg1;
            if (md_reg1 == md_reg2) begin
              wdata1 = md_data2;
              rw     = RW_ONE;
            end else begin
              wdata1 = md_data1;
              wreg2  = md_reg2;
              wdata2 = md_data2;
              rw     = RW_TWO;
            end
            first         = REQ_MD;
            grant[REQ_MD] = 1'b1;
            slots         = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback scheduler for the two-write-port register file: holds the round-robin pointer and
// the registered write ports, and exports which registers are currently being written.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_stall,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AW-1:0]       alu_reg,
  input  logic [DW-1:0]       alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [AW-1:0]       mem_reg,
  input  logic [DW-1:0]       mem_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [AW-1:0]       md_reg1,
  input  logic [AW-1:0]       md_reg2,
  input  logic [DW-1:0]       md_data1,
  input  logic [DW-1:0]       md_data2,
  output logic [1:0]          RegWrite,
  output logic [AW-1:0]       WriteReg1,
  output logic [AW-1:0]       WriteReg2,
  output logic [DW-1:0]       WriteData1,
  output logic [DW-1:0]       WriteData2,
  output logic [NUM_REGS-1:0] pend_mask
);

  req_id_e             ptr;
  logic [2:0]          valid;
  logic [2:0]          grant;
  logic [1:0]          first;
  logic [1:0]          rw;
  logic [AW-1:0]       wreg1;
  logic [AW-1:0]       wreg2;
  logic [DW-1:0]       wdata1;
  logic [DW-1:0]       wdata2;
  logic [NUM_REGS-1:0] pend_next;

  // Nothing is offered a slot while stalled or held in reset.
  assign valid = {md_valid, mem_valid, alu_valid} & {3{~wb_stall & ~reset}};

  wb_slot_alloc u_alloc (
    .ptr      (ptr),
    .valid    (valid),
    .alu_reg  (alu_reg),
    .alu_data (alu_data),
    .mem_reg  (mem_reg),
    .mem_data (mem_data),
    .md_reg1  (md_reg1),
    .md_reg2  (md_reg2),
    .md_data1 (md_data1),
    .md_data2 (md_data2),
    .grant    (grant),
    .first    (first),
    .rw       (rw),
    .wreg1    (wreg1),
    .wreg2    (wreg2),
    .wdata1   (wdata1),
    .wdata2   (wdata2)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign md_ready  = grant[REQ_MD];

  always_comb begin
    pend_next = '0;
    if (rw != RW_NONE) pend_next[wreg1] = 1'b1;
    if (rw == RW_TWO)  pend_next[wreg2] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWrite   <= RW_NONE;
      WriteReg1  <= '0;
      WriteReg2  <= '0;
      WriteData1 <= '0;
      WriteData2 <= '0;
      pend_mask  <= '0;
      ptr        <= REQ_ALU;
    end else begin
      RegWrite  <= rw;
      pend_mask <= pend_next;
      if (rw != RW_NONE) begin
        WriteReg1  <= wreg1;
        WriteData1 <= wdata1;
        ptr        <= req_after(req_id_e'(first));
      end
      if (rw == RW_TWO) begin
        WriteReg2  <= wreg2;
        WriteData2 <= wdata2;
      end
    end
  end

endmodule
